ff_pipe_elastic: RTL and testbench

Parametrised elastic register pipeline: WIDTH-bit data through DEPTH register stages, each stage with its own valid bit. Stages advance under valid/ready backpressure, so bubbles collapse when the output stalls. Adds a global clock enable, a synchronous flush and a registered occupancy count. Used wherever a plain CE/SR flip-flop needs depth, width and flow control, e.g. retiming long routes between handshaking blocks.

---
 rtl/ff_pkg.sv | 9 +
 rtl/ff_stage.sv | 31 +++
 rtl/ff_pipe_elastic.sv | 90 +++++++++
 tb/tb_ff_pipe_elastic.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared helpers for the CH4 register-pipeline blocks.
package ff_pkg;

   // Bits needed to count 0..depth inclusive.
   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ff_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit data register.
module ff_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CK,
   input  logic             SR,
   input  logic             CE,
   input  logic             FLUSH,
   input  logic             load,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge CK or posedge SR) begin
      if (SR) begin
         valid <= 1'b0;
         data  <= RESET_VAL;
      end else if (FLUSH) begin
         valid <= 1'b0;
         data  <= RESET_VAL;
      end else if (CE && load) begin
         valid <= in_valid;
         // A bubble moving in leaves the old data in place.
         if (in_valid) data <= in_data;
      end
   end

endmodule

// File: rtl/ff_pipe_elastic.sv
// Elastic valid/ready register pipeline with clock enable, flush and occupancy count.
module ff_pipe_elastic
   import ff_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        CK,
   input  logic                        SR,
   input  logic                        CE,
   input  logic                        FLUSH,
   input  logic                        I_VALID,
   output logic                        I_READY,
   input  logic [WIDTH-1:0]            D,
   output logic                        O_VALID,
   input  logic                        O_READY,
   output logic [WIDTH-1:0]            Q,
   output logic [occ_w(DEPTH)-1:0]     OCCUPANCY
);

   localparam int             OW      = occ_w(DEPTH);
   localparam logic [OW-1:0]  OCC_ONE = OW'(1);

   if (DEPTH < 1) begin : g_depth_chk
      $error("ff_pipe_elastic: DEPTH must be >= 1");
   end

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH:0]   adv;
   logic             in_xfer;
   logic             out_xfer;

   // A stage may load when it is empty or its successor is moving on.
   always_comb begin
      adv        = '0;
      adv[DEPTH] = O_READY;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         adv[i] = !valid[i] || adv[i+1];
      end
   end

   assign I_READY  = CE && adv[0];
   assign in_xfer  = I_VALID && I_READY;
   assign out_xfer = CE && O_VALID && O_READY;
   assign O_VALID  = valid[DEPTH-1];
   assign Q        = data[DEPTH-1];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (i == 0) begin : g_head
         assign src_valid = I_VALID;
         assign src_data  = D;
      end else begin : g_body
         assign src_valid = valid[i-1];
         assign src_data  = data[i-1];
      end

      ff_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .CK       (CK),
         .SR       (SR),
         .CE       (CE),
         .FLUSH    (FLUSH),
         .load     (adv[i]),
         .in_valid (src_valid),
         .in_data  (src_data),
         .valid    (valid[i]),
         .data     (data[i])
      );
   end

   always_ff @(posedge CK or posedge SR) begin
      if (SR) begin
         OCCUPANCY <= '0;
      end else if (FLUSH) begin
         OCCUPANCY <= '0;
      end else if (in_xfer && !out_xfer) begin
         OCCUPANCY <= OCCUPANCY + OCC_ONE;
      end else if (!in_xfer && out_xfer) begin
         OCCUPANCY <= OCCUPANCY - OCC_ONE;
      end
   end

endmodule

// File: tb/tb_ff_pipe_elastic.sv
// Self-checking bench for ff_pipe_elastic: queue-based model plus directed literal checks.
module tb_ff_pipe_elastic;
   import ff_pkg::*;

   localparam int         MD = 4;
   localparam logic [7:0] RV = 8'hA5;

   logic       CK = 1'b0;
   logic       SR = 1'b0;
   logic       CE = 1'b1;
   logic       FLUSH = 1'b0;
   logic       I_VALID = 1'b0;
   logic       O_READY = 1'b0;
   logic [7:0] D = 8'h00;
   logic       I_READY;
   logic       O_VALID;
   logic [7:0] Q;
   logic [2:0] OCCUPANCY;

   logic       b_ce = 1'b1;
   logic       b_flush = 1'b0;
   logic       b_i_valid = 1'b0;
   logic       b_o_ready = 1'b0;
   logic [0:0] b_d = 1'b0;
   logic       b_i_ready;
   logic       b_o_valid;
   logic [0:0] b_q;
   logic [0:0] b_occ;

   int n_cmp = 0;
   int n_err = 0;

   ff_pipe_elastic #(.WIDTH(8), .DEPTH(MD), .RESET_VAL(RV)) dut (
      .CK(CK), .SR(SR), .CE(CE), .FLUSH(FLUSH),
      .I_VALID(I_VALID), .I_READY(I_READY), .D(D),
      .O_VALID(O_VALID), .O_READY(O_READY), .Q(Q), .OCCUPANCY(OCCUPANCY)
   );

   ff_pipe_elastic #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut_b (
      .CK(CK), .SR(SR), .CE(b_ce), .FLUSH(b_flush),
      .I_VALID(b_i_valid), .I_READY(b_i_ready), .D(b_d),
      .O_VALID(b_o_valid), .O_READY(b_o_ready), .Q(b_q), .OCCUPANCY(b_occ)
   );

   always #5 CK = ~CK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   // Model: words in flight, oldest first, each tagged with its stage position.
   typedef struct {
      logic [7:0] d;
      int         pos;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] m_q = RV;

   function automatic logic m_ovalid();
      return (mq.size() > 0) && (mq[0].pos == MD - 1);
   endfunction

   // Input is accepted unless the run of occupied stages from the input reaches the stalled output.
   function automatic logic m_iready();
      int run = 0;
      for (int k = mq.size() - 1; k >= 0; k--) begin
         if (mq[k].pos == run) run++;
         else break;
      end
      return CE && ((run < MD) || O_READY);
   endfunction

   task automatic model_step();
      logic in_x, out_x;
      int   limit, np;
      if (FLUSH) begin
         mq.delete();
         m_q = RV;
         return;
      end
      if (!CE) return;
      in_x  = I_VALID && m_iready();
      out_x = m_ovalid() && O_READY;
      if (out_x) void'(mq.pop_front());
      limit = MD - 1;
      for (int k = 0; k < mq.size(); k++) begin
         np = (mq[k].pos + 1 < limit) ? mq[k].pos + 1 : limit;
         mq[k].pos = np;
         if (np == MD - 1) m_q = mq[k].d;
         limit = np - 1;
      end
      if (in_x) begin
         mq.push_back('{d: D, pos: 0});
         if (MD == 1) m_q = D;
      end
   endtask

   always @(posedge CK or posedge SR) begin
      if (SR) begin
         mq.delete();
         m_q = RV;
      end else begin
         model_step();
      end
   end

   always @(negedge CK) begin
      chk("model_o_valid", {31'd0, O_VALID}, {31'd0, m_ovalid()});
      chk("model_q", {24'd0, Q}, {24'd0, m_q});
      chk("model_occupancy", {29'd0, OCCUPANCY}, mq.size());
      chk("model_i_ready", {31'd0, I_READY}, {31'd0, m_iready()});
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat;
      logic [7:0] bp_words [4];
      pat = 8'b1011_0010;
      bp_words[0] = 8'h11; bp_words[1] = 8'h22; bp_words[2] = 8'h33; bp_words[3] = 8'h44;

      #1 SR = 1'b1;
      repeat (2) @(posedge CK);
      #1 SR = 1'b0;
      chk("reset_o_valid", {31'd0, O_VALID}, 0);
      chk("reset_q", {24'd0, Q}, 32'hA5);
      chk("reset_occ", {29'd0, OCCUPANCY}, 0);
      chk("reset_i_ready", {31'd0, I_READY}, 1);
      chk("b_reset_o_valid", {31'd0, b_o_valid}, 0);
      chk("b_reset_occ", {31'd0, b_occ}, 0);

      // Streaming
      O_READY = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         I_VALID = 1'b1;
         D = 8'(k);
         step();
         if (k >= 4) begin
            chk("stream_q", {24'd0, Q}, k - 3);
            chk("stream_o_valid", {31'd0, O_VALID}, 1);
            chk("stream_occ", {29'd0, OCCUPANCY}, 4);
            chk("stream_i_ready", {31'd0, I_READY}, 1);
         end
      end
      I_VALID = 1'b0;
      repeat (4) step();
      chk("drain_o_valid", {31'd0, O_VALID}, 0);

      // Backpressure
      O_READY = 1'b0;
      for (int k = 0; k < 4; k++) begin
         I_VALID = 1'b1;
         D = bp_words[k];
         step();
      end
      I_VALID = 1'b0;
      #1;
      chk("bp_occ", {29'd0, OCCUPANCY}, 4);
      chk("bp_i_ready_full", {31'd0, I_READY}, 0);
      chk("bp_q", {24'd0, Q}, 32'h11);
      O_READY = 1'b1;
      #1;
      chk("bp_i_ready_full_ordy", {31'd0, I_READY}, 1);
      for (int k = 0; k < 4; k++) begin
         chk("bp_out_q", {24'd0, Q}, {24'd0, bp_words[k]});
         chk("bp_out_valid", {31'd0, O_VALID}, 1);
         step();
      end
      chk("bp_empty", {31'd0, O_VALID}, 0);

      // Bubble collapse
      O_READY = 1'b0;
      I_VALID = 1'b1; D = 8'hAA; step();
      I_VALID = 1'b0; step(); step();
      I_VALID = 1'b1; D = 8'hBB; step();
      I_VALID = 1'b0;
      repeat (3) step();
      chk("bubble_occ", {29'd0, OCCUPANCY}, 2);
      chk("bubble_q", {24'd0, Q}, 32'hAA);
      chk("bubble_o_valid", {31'd0, O_VALID}, 1);
      O_READY = 1'b1;
      step();
      chk("bubble_q2", {24'd0, Q}, 32'hBB);
      step();
      chk("bubble_drained", {31'd0, O_VALID}, 0);

      // Clock enable freeze
      for (int k = 1; k <= 3; k++) begin
         I_VALID = 1'b1;
         D = 8'h50 + 8'(k);
         step();
      end
      CE = 1'b0;
      D = 8'h99;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ce_occ", {29'd0, OCCUPANCY}, 3);
         chk("ce_i_ready", {31'd0, I_READY}, 0);
         chk("ce_o_valid", {31'd0, O_VALID}, 0);
      end
      CE = 1'b1;
      I_VALID = 1'b0;
      step();
      chk("ce_resume_q", {24'd0, Q}, 32'h51);
      chk("ce_resume_valid", {31'd0, O_VALID}, 1);

      // Flush with CE low and a word offered
      FLUSH = 1'b1; CE = 1'b0; I_VALID = 1'b1; D = 8'h77;
      step();
      FLUSH = 1'b0; CE = 1'b1; I_VALID = 1'b0;
      chk("flush_o_valid", {31'd0, O_VALID}, 0);
      chk("flush_q", {24'd0, Q}, 32'hA5);
      chk("flush_occ", {29'd0, OCCUPANCY}, 0);
      repeat (4) step();
      chk("flush_dropped", {31'd0, O_VALID}, 0);

      // Asynchronous reset with the pipe full
      O_READY = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         I_VALID = 1'b1;
         D = 8'hC0 + 8'(k);
         step();
      end
      I_VALID = 1'b0;
      chk("full_before_sr", {29'd0, OCCUPANCY}, 4);
      #2 SR = 1'b1;
      #1;
      chk("sr_o_valid", {31'd0, O_VALID}, 0);
      chk("sr_q", {24'd0, Q}, 32'hA5);
      chk("sr_occ", {29'd0, OCCUPANCY}, 0);
      chk("sr_i_ready", {31'd0, I_READY}, 1);
      CE = 1'b0;
      #1;
      chk("sr_i_ready_ce0", {31'd0, I_READY}, 0);
      CE = 1'b1;
      @(posedge CK);
      #1 SR = 1'b0;
      O_READY = 1'b1;
      I_VALID = 1'b1; D = 8'hE1; step();
      I_VALID = 1'b0;
      repeat (3) step();
      chk("post_sr_q", {24'd0, Q}, 32'hE1);
      chk("post_sr_valid", {31'd0, O_VALID}, 1);
      step();
      chk("post_sr_empty", {31'd0, O_VALID}, 0);

      // DEPTH=1, WIDTH=1 pass-through
      b_o_ready = 1'b1;
      b_i_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         b_d = pat[k];
         step();
         chk("b_q", {31'd0, b_q}, {31'd0, pat[k]});
         chk("b_o_valid", {31'd0, b_o_valid}, 1);
         chk("b_occ", {31'd0, b_occ}, 1);
         chk("b_i_ready", {31'd0, b_i_ready}, 1);
      end
      b_i_valid = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
